// File: rtl/vga_mem_arbiter.sv
// Screen-memory arbiter: the display tile prefetch takes the pixel-tick cycle when a
// tile is due; every other cycle is shared round-robin between R0 (CPU) and R1 (blitter).
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned COLS        = 80,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned WHOLE_LINE  = 800,
    parameter int unsigned WHOLE_FRAME = 525
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned XY_W  = 10;
    localparam int unsigned MAP_W = 16;

    logic [1:0]        phase;      // pixel sub-cycle; the pix_tick cycle is phase 0
    logic              armed;      // low for the first cycle after reset release
    logic              rr_ptr;     // requester that wins a tie: 0 = R0, 1 = R1
    logic [XY_W-1:0]   xn;
    logic [XY_W-1:0]   yn;
    logic              dfetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] r0_hold;
    logic [DATA_W-1:0] r1_hold;
    logic [DATA_W-1:0] disp_hold;

    // Next pixel position and the display prefetch decision for this cycle
    always_comb begin
        xn = x + XY_W'(1);
        yn = y;
        if (x == XY_W'(WHOLE_LINE - 1)) begin
            xn = '0;
            yn = (y == XY_W'(WHOLE_FRAME - 1)) ? '0 : y + XY_W'(1);
        end
        dfetch = armed && pix_tick && (x[2:0] == 3'd7)
              && (x < XY_W'(WHOLE_LINE)) && (y < XY_W'(WHOLE_FRAME))
              && (xn < XY_W'(H_ACTIVE)) && (yn < XY_W'(V_ACTIVE));
        fetch_addr = ADDR_W'(MAP_W'(yn >> 3) * MAP_W'(COLS) + MAP_W'(xn >> 3));
    end

    // Requester grant: only in non-fetch cycles, round-robin on a tie
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (armed && !dfetch) begin
            if (r0_req && r1_req) begin
                r0_gnt = ~rr_ptr;
                r1_gnt = rr_ptr;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    // Memory port mux; idle cycles drive all-zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dfetch) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (r0_gnt) begin
            mem_en    = 1'b1;
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (r1_gnt) begin
            mem_en    = 1'b1;
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // Phase counter, start-up guard and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 2'd0;
            armed  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            phase <= pix_tick ? 2'd1 : phase + 2'd1;
            armed <= 1'b1;
            if (r0_gnt) begin
                rr_ptr <= 1'b1;
            end else if (r1_gnt) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // Read-return tracking; reads in flight at reset are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            disp_valid <= 1'b0;
            r0_hold    <= '0;
            r1_hold    <= '0;
            disp_hold  <= '0;
        end else begin
            r0_rvalid  <= r0_gnt & ~r0_we;
            r1_rvalid  <= r1_gnt & ~r1_we;
            disp_valid <= dfetch;
            if (r0_rvalid) begin
                r0_hold <= mem_rdata;
            end
            if (r1_rvalid) begin
                r1_hold <= mem_rdata;
            end
            if (disp_valid) begin
                disp_hold <= mem_rdata;
            end
        end
    end

    // Returned data follows memory in the valid cycle, then holds until the next read
    assign r0_rdata  = r0_rvalid  ? mem_rdata : r0_hold;
    assign r1_rdata  = r1_rvalid  ? mem_rdata : r1_hold;
    assign disp_data = disp_valid ? mem_rdata : disp_hold;

endmodule
